// File: rtl/flappy_pkg.sv
// Shared constants and types for the flappy game blocks.
//   SCREEN_W / SCREEN_H : playfield size in pixels
//   PIPE_W              : pipe width in pixels
//   BIRD_X              : fixed bird column used for scoring
//   GAP_MIN / GAP_MAX   : legal range of the random gap value
//   pipe_state_t        : sequencing states of the pipe spawner
package flappy_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int PIPE_W   = 10;
  localparam int BIRD_X   = 40;
  localparam int GAP_MIN  = 20;
  localparam int GAP_MAX  = 98;

  localparam int X_W     = 8;
  localparam int GAP_W   = 7;
  localparam int N_SLOTS = 3;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_WAIT_TICK   = 3'd1,
    ST_MOVE        = 3'd2,
    ST_SPAWN_REQ   = 3'd3,
    ST_SPAWN_WAIT  = 3'd4,
    ST_SPAWN_LATCH = 3'd5
  } pipe_state_t;

endpackage

// File: rtl/pipe_slot.sv
// One on-screen pipe: occupancy flag, left-edge x and gap top.
//   clk, reset_n : clock and synchronous active-low reset
//   move         : shift left by SPEED this cycle (retire if too close to 0)
//   load         : place a new pipe at the right edge with gap load_gap
//   valid/x/gap  : current slot contents
//   leaving      : slot is valid and would retire on a move
//   pass_bird    : a move this cycle carries the right edge past BIRD_X
module pipe_slot
  import flappy_pkg::*;
#(
  parameter int SPEED = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             move,
  input  logic             load,
  input  logic [GAP_W-1:0] load_gap,
  output logic             valid,
  output logic [X_W-1:0]   x,
  output logic [GAP_W-1:0] gap,
  output logic             leaving,
  output logic             pass_bird
);

  localparam int XE_W = X_W + 1;

  logic             valid_q, valid_d;
  logic [X_W-1:0]   x_q, x_d;
  logic [GAP_W-1:0] gap_q, gap_d;

  // One extra bit so x + PIPE_W cannot overflow near the right edge.
  logic [XE_W-1:0] x_ext;
  logic [XE_W-1:0] right_now;
  logic [XE_W-1:0] right_after;

  always_comb begin
    x_ext       = {1'b0, x_q};
    leaving     = valid_q && (x_ext < XE_W'(SPEED));
    right_now   = x_ext + XE_W'(PIPE_W);
    right_after = x_ext - XE_W'(SPEED) + XE_W'(PIPE_W);
    // A retiring pipe never scores; its right edge is already left of the bird.
    pass_bird   = valid_q && !leaving &&
                  (right_now > XE_W'(BIRD_X)) && (right_after <= XE_W'(BIRD_X));

    valid_d = valid_q;
    x_d     = x_q;
    gap_d   = gap_q;
    if (load) begin
      valid_d = 1'b1;
      x_d     = X_W'(SCREEN_W);
      gap_d   = load_gap;
    end else if (move && valid_q) begin
      if (leaving) begin
        valid_d = 1'b0;
        x_d     = X_W'(SCREEN_W);
      end else begin
        x_d = x_q - X_W'(SPEED);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      x_q     <= X_W'(SCREEN_W);
      gap_q   <= '0;
    end else begin
      valid_q <= valid_d;
      x_q     <= x_d;
      gap_q   <= gap_d;
    end
  end

  assign valid = valid_q;
  assign x     = x_q;
  assign gap   = gap_q;

endmodule

// File: rtl/pipe_spawner.sv
// Owns the set of on-screen pipes: scrolls them once per frame tick,
// retires those leaving the screen and spawns new ones at the right edge.
//   clk, reset_n         : clock and synchronous active-low reset
//   run                  : game active; low freezes the pipe set
//   frame_tick           : one-cycle pulse per frame
//   rand_q               : gap value from the random block
//   rand_en              : one-cycle advance pulse to the random block
//   pipe_valid           : per-slot occupied flags
//   pipeN_x / pipeN_gap  : per-slot left edge and gap top
//   score_pulse          : one-cycle pulse when a pipe passes the bird
module pipe_spawner
  import flappy_pkg::*;
#(
  parameter int SPACING = 60,
  parameter int SPEED   = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             run,
  input  logic             frame_tick,
  input  logic [GAP_W-1:0] rand_q,
  output logic             rand_en,
  output logic [2:0]       pipe_valid,
  output logic [X_W-1:0]   pipe0_x,
  output logic [X_W-1:0]   pipe1_x,
  output logic [X_W-1:0]   pipe2_x,
  output logic [GAP_W-1:0] pipe0_gap,
  output logic [GAP_W-1:0] pipe1_gap,
  output logic [GAP_W-1:0] pipe2_gap,
  output logic             score_pulse
);

  pipe_state_t state_q, state_d;
  logic [7:0]  dist_q, dist_d;
  logic        tick_pend_q, tick_pend_d;
  logic        rand_en_q, rand_en_d;
  logic        score_q, score_d;

  logic [N_SLOTS-1:0] valid_w;
  logic [N_SLOTS-1:0] leave_w;
  logic [N_SLOTS-1:0] pass_w;
  logic [N_SLOTS-1:0] load_w;
  logic [X_W-1:0]     x_w   [N_SLOTS];
  logic [GAP_W-1:0]   gap_w [N_SLOTS];

  logic       move_w;
  logic [1:0] free_idx;
  logic       any_free_now;
  logic [8:0] dist_sum;

  assign move_w = (state_q == ST_MOVE);

  // Lowest-index empty slot, evaluated at latch time.
  always_comb begin
    free_idx     = '0;
    any_free_now = 1'b0;
    for (int i = N_SLOTS - 1; i >= 0; i--) begin
      if (!valid_w[i]) begin
        free_idx     = 2'(i);
        any_free_now = 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < N_SLOTS; gi++) begin : g_slot
    assign load_w[gi] = (state_q == ST_SPAWN_LATCH) && any_free_now &&
                        (free_idx == 2'(gi));

    pipe_slot #(
      .SPEED(SPEED)
    ) u_slot (
      .clk      (clk),
      .reset_n  (reset_n),
      .move     (move_w),
      .load     (load_w[gi]),
      .load_gap (rand_q),
      .valid    (valid_w[gi]),
      .x        (x_w[gi]),
      .gap      (gap_w[gi]),
      .leaving  (leave_w[gi]),
      .pass_bird(pass_w[gi])
    );
  end

  always_comb begin
    state_d     = state_q;
    dist_d      = dist_q;
    tick_pend_d = tick_pend_q;
    rand_en_d   = 1'b0;
    score_d     = 1'b0;
    dist_sum    = {1'b0, dist_q} + 9'(SPEED);

    // A tick that cannot be consumed right now is remembered once.
    if (run && frame_tick && (state_q != ST_WAIT_TICK)) begin
      tick_pend_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_WAIT_TICK;
      end
      ST_WAIT_TICK: begin
        if (run && (frame_tick || tick_pend_q)) begin
          tick_pend_d = 1'b0;
          state_d     = ST_MOVE;
        end
      end
      ST_MOVE: begin
        score_d = |pass_w;
        dist_d  = (dist_sum >= 9'(SPACING)) ? 8'(SPACING) : dist_sum[7:0];
        // Slots retiring in this move already count as free.
        if ((dist_d >= 8'(SPACING)) && |(~valid_w | leave_w)) begin
          state_d   = ST_SPAWN_REQ;
          rand_en_d = 1'b1;
        end else if (run) begin
          state_d = ST_WAIT_TICK;
        end else begin
          state_d     = ST_IDLE;
          tick_pend_d = 1'b0;
        end
      end
      ST_SPAWN_REQ: begin
        state_d = ST_SPAWN_WAIT;
      end
      ST_SPAWN_WAIT: begin
        state_d = ST_SPAWN_LATCH;
      end
      ST_SPAWN_LATCH: begin
        dist_d = '0;
        if (run) begin
          state_d = ST_WAIT_TICK;
        end else begin
          state_d     = ST_IDLE;
          tick_pend_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      dist_q      <= 8'(SPACING);
      tick_pend_q <= 1'b0;
      rand_en_q   <= 1'b0;
      score_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      dist_q      <= dist_d;
      tick_pend_q <= tick_pend_d;
      rand_en_q   <= rand_en_d;
      score_q     <= score_d;
    end
  end

  assign rand_en     = rand_en_q;
  assign score_pulse = score_q;
  assign pipe_valid  = valid_w;
  assign pipe0_x     = x_w[0];
  assign pipe1_x     = x_w[1];
  assign pipe2_x     = x_w[2];
  assign pipe0_gap   = gap_w[0];
  assign pipe1_gap   = gap_w[1];
  assign pipe2_gap   = gap_w[2];

endmodule
